// File: rtl/i2s_frame_scheduler_pkg.sv
// Shared types and helpers for the I2S frame scheduler and its neighbours.
// Holds the sequencer state encoding, the default sample width and the signed clamp.
package i2s_frame_scheduler_pkg;

   localparam int SAMPLE_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_SAT,
      ST_SEND_WAIT
   } sched_state_t;

   // Clamps a signed value into the range representable by a signed 'width'-bit word.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
      logic signed [63:0] maxVal;
      logic signed [63:0] minVal;
      logic signed [63:0] result;
      maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
      minVal = -(64'sd1 <<< (width - 1));
      result = value;
      if (value > maxVal) begin
         result = maxVal;
      end else if (value < minVal) begin
         result = minVal;
      end
      return result;
   endfunction

endpackage

// File: rtl/i2s_frame_scheduler_if.sv
// Bundles the voice request bus, the i2s_controller handoff and the status flags.
// The master modport is the scheduler side; slave is the surrounding system.
interface i2s_frame_scheduler_if
   import i2s_frame_scheduler_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
   parameter int IDX_W      = $clog2(NUM_VOICES)
);
   logic                       frame_tick;
   logic [NUM_VOICES-1:0]      voice_mask;
   logic                       voice_req;
   logic [IDX_W-1:0]           voice_sel;
   logic                       voice_valid;
   logic signed [SAMPLE_W-1:0] voice_left;
   logic signed [SAMPLE_W-1:0] voice_right;
   logic                       i2s_ready;
   logic                       send;
   logic signed [SAMPLE_W-1:0] sample_left;
   logic signed [SAMPLE_W-1:0] sample_right;
   logic                       busy;
   logic                       clear_flags;
   logic                       timeout_err;
   logic                       overrun;

   modport master (
      input  frame_tick, voice_mask, voice_valid, voice_left, voice_right, i2s_ready, clear_flags,
      output voice_req, voice_sel, send, sample_left, sample_right, busy, timeout_err, overrun
   );

   modport slave (
      output frame_tick, voice_mask, voice_valid, voice_left, voice_right, i2s_ready, clear_flags,
      input  voice_req, voice_sel, send, sample_left, sample_right, busy, timeout_err, overrun
   );

endinterface

// File: rtl/i2s_frame_scheduler_mix_saturator.sv
// Combinational signed clamp of a wide mix accumulator down to the output sample width.
module mix_saturator
   import i2s_frame_scheduler_pkg::*;
#(
   parameter int IN_W  = 18,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  i_value,
   output logic signed [OUT_W-1:0] o_value
);

   logic signed [63:0] w_clamped;

   assign w_clamped = saturate(64'(i_value), OUT_W);
   assign o_value   = OUT_W'(w_clamped);

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Per-frame sequencer: polls enabled voices one at a time, sums and clamps the stereo mix,
// then launches it to i2s_controller; flags voice timeouts and ticks that arrive mid-frame.
module i2s_frame_scheduler
   import i2s_frame_scheduler_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
   parameter int TIMEOUT    = 63,
   parameter int IDX_W      = $clog2(NUM_VOICES)
) (
   input logic clk,
   input logic reset,
   i2s_frame_scheduler_if.master bus
);

   localparam int ACC_W   = SAMPLE_W + IDX_W;
   localparam int TIMER_W = $clog2(TIMEOUT + 1);

   sched_state_t               r_state;
   sched_state_t               w_nextState;
   logic [NUM_VOICES-1:0]      r_mask;
   logic [IDX_W-1:0]           r_idx;
   logic [TIMER_W-1:0]         r_timer;
   logic signed [ACC_W-1:0]    r_accLeft;
   logic signed [ACC_W-1:0]    r_accRight;
   logic signed [SAMPLE_W-1:0] r_sampleLeft;
   logic signed [SAMPLE_W-1:0] r_sampleRight;
   logic signed [SAMPLE_W-1:0] w_satLeft;
   logic signed [SAMPLE_W-1:0] w_satRight;
   logic                       r_timeoutErr;
   logic                       r_overrun;
   logic                       w_lastVoice;
   logic                       w_timeoutHit;
   logic                       w_advance;
   logic                       w_voiceReq;
   logic [IDX_W-1:0]           w_voiceSel;
   logic                       w_send;
   logic                       w_busy;

   assign w_lastVoice  = (r_idx == IDX_W'(NUM_VOICES - 1));
   assign w_timeoutHit = (r_state == ST_WAIT) && !bus.voice_valid && (r_timer == TIMER_W'(TIMEOUT - 1));

   always_comb begin
      w_nextState = r_state;
      w_advance   = 1'b0;
      w_voiceReq  = 1'b0;
      w_voiceSel  = '0;
      w_send      = 1'b0;
      w_busy      = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (bus.frame_tick) w_nextState = ST_REQ;
         end
         ST_REQ: begin
            w_voiceSel = r_idx;
            if (r_mask[r_idx]) begin
               w_voiceReq  = 1'b1;
               w_nextState = ST_WAIT;
            end else begin
               w_advance   = 1'b1;
               w_nextState = w_lastVoice ? ST_SAT : ST_REQ;
            end
         end
         ST_WAIT: begin
            w_voiceSel = r_idx;
            if (bus.voice_valid || w_timeoutHit) begin
               w_advance   = 1'b1;
               w_nextState = w_lastVoice ? ST_SAT : ST_REQ;
            end
         end
         ST_SAT: begin
            w_nextState = ST_SEND_WAIT;
         end
         ST_SEND_WAIT: begin
            if (bus.i2s_ready) begin
               w_send      = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_mask        <= '0;
         r_idx         <= '0;
         r_timer       <= '0;
         r_accLeft     <= '0;
         r_accRight    <= '0;
         r_sampleLeft  <= '0;
         r_sampleRight <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_IDLE && bus.frame_tick) begin
            r_mask     <= bus.voice_mask;
            r_idx      <= '0;
            r_accLeft  <= '0;
            r_accRight <= '0;
         end
         if (r_state == ST_REQ) r_timer <= '0;
         if (r_state == ST_WAIT && !bus.voice_valid && !w_timeoutHit) r_timer <= r_timer + 1'b1;
         if (r_state == ST_WAIT && bus.voice_valid) begin
            r_accLeft  <= r_accLeft + ACC_W'(bus.voice_left);
            r_accRight <= r_accRight + ACC_W'(bus.voice_right);
         end
         if (w_advance && !w_lastVoice) r_idx <= r_idx + 1'b1;
         if (r_state == ST_SAT) begin
            r_sampleLeft  <= w_satLeft;
            r_sampleRight <= w_satRight;
         end
      end
   end

   // Sticky flags: a set event in the same cycle as clear_flags takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_timeoutErr <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_timeoutHit) r_timeoutErr <= 1'b1;
         else if (bus.clear_flags) r_timeoutErr <= 1'b0;
         if (bus.frame_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
         else if (bus.clear_flags) r_overrun <= 1'b0;
      end
   end

   mix_saturator #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_satLeft (
      .i_value (r_accLeft),
      .o_value (w_satLeft)
   );

   mix_saturator #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_satRight (
      .i_value (r_accRight),
      .o_value (w_satRight)
   );

   assign bus.voice_req    = w_voiceReq;
   assign bus.voice_sel    = w_voiceSel;
   assign bus.send         = w_send;
   assign bus.busy         = w_busy;
   assign bus.sample_left  = r_sampleLeft;
   assign bus.sample_right = r_sampleRight;
   assign bus.timeout_err  = r_timeoutErr;
   assign bus.overrun      = r_overrun;

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
Per-frame sequencer sitting between the synth voice generators and i2s_controller. On each sample-rate tick it polls every enabled voice over a shared request/valid bus, sums the left and right samples with saturation, then hands the stereo result to i2s_controller with a one-cycle send pulse once that controller reports ready. It also flags voices that fail to answer (timeout) and ticks that arrive while a frame is still in progress (overrun).

Parameters:
NUM_VOICES, 4, number of voice requesters polled per frame (at least 2).
SAMPLE_W, 16, signed sample width, and the width of the i2s_controller sample ports.
TIMEOUT, 63, maximum number of WAIT cycles per voice before its contribution is forced to 0.
IDX_W, $clog2(NUM_VOICES), width of voice_sel.

Ports:
clk  in  1  system clock; the only clock in the block.
reset  in  1  synchronous, active-high reset.
frame_tick  in  1  one-cycle strobe at the sample rate; starts a frame.
voice_mask  in  NUM_VOICES  bit i = 1 means voice i is polled; sampled when a frame starts.
voice_req  out  1  one-cycle request to the voice addressed by voice_sel.
voice_sel  out  IDX_W  index of the voice currently being polled.
voice_valid  in  1  the addressed voice presents its samples this cycle.
voice_left  in  SAMPLE_W  signed left sample, valid while voice_valid is high.
voice_right  in  SAMPLE_W  signed right sample, valid while voice_valid is high.
i2s_ready  in  1  ready output of i2s_controller.
send  out  1  one-cycle launch pulse to i2s_controller.
sample_left  out  SAMPLE_W  mixed left sample driven to i2s_controller.
sample_right  out  SAMPLE_W  mixed right sample driven to i2s_controller.
busy  out  1  high whenever the state is not IDLE.
clear_flags  in  1  clears timeout_err and overrun.
timeout_err  out  1  sticky; set when any voice times out.
overrun  out  1  sticky; set when frame_tick arrives while busy.

Behaviour:
- Reset values: all outputs 0; state = IDLE; accumulators, idx and timer all 0.
- States: IDLE, REQ, WAIT, SAT, SEND_WAIT.
- IDLE:
  - On frame_tick: latch voice_mask, clear both accumulators, set idx = 0, go to REQ.
- REQ:
  - If mask[idx] = 1: drive voice_req = 1 for this cycle only, voice_sel = idx, clear timer, go to WAIT.
  - If mask[idx] = 0: no request is made; advance as described under "Advance".
  - voice_sel holds idx in both REQ and WAIT.
- WAIT:
  - voice_valid is sampled only in this state. Any voice_valid seen in REQ or IDLE is ignored.
  - On voice_valid: add the sign-extended voice_left and voice_right to their accumulators, then advance.
  - Otherwise increment timer. When timer reaches TIMEOUT (with no valid in that cycle): set timeout_err, contribute 0, advance.
- Advance:
  - If idx = NUM_VOICES-1, go to SAT.
  - Otherwise idx increments and the state returns to REQ.
- Accumulator width: SAMPLE_W + IDX_W, signed. No intermediate overflow is possible.
- SAT:
  - Clamp each accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Register the results into sample_left and sample_right.
  - Go to SEND_WAIT.
- SEND_WAIT:
  - When i2s_ready = 1: send = 1 for exactly one cycle, then go to IDLE.
  - sample_left and sample_right change only in SAT, so they are stable at least one cycle before send and for the whole serial frame.
- Latency: with all voices answering in the cycle after their request, send is asserted 2*NUM_VOICES + 2 cycles after frame_tick (assuming i2s_ready is already high).
- Mask of all zeros: REQ skips every voice, and a frame of 0/0 is still sent.
- frame_tick while busy: set overrun and drop the tick. The frame in progress is unaffected.
- clear_flags in the same cycle as a set event: the set wins.
- Reset mid-frame: the state returns to IDLE in the next cycle, with no send and no voice_req.
- The voice bus is strictly one outstanding request at a time.

Decomposition:
- Shared package: the state enumeration, the saturate function (parameterised by width), and the SAMPLE_W default shared with i2s_controller.
- One natural sub-module: mix_saturator, the combinational signed clamp from SAMPLE_W+IDX_W bits down to SAMPLE_W. It is instantiated twice, once per channel.

Test Plan:
1. Mask 4'b1111, voices answer one cycle after voice_req with L = 1000, 2000, -500, 0 and R = 10 each; i2s_ready = 1 -> sample_left = 2500, sample_right = 40, send pulses exactly 10 cycles after frame_tick.
2. Four voices each L = 16'h7000 -> sample_left = 32767; four voices each L = 16'h9000 -> sample_left = -32768.
3. Mask 4'b0101 -> voice_req asserted only with voice_sel = 0 and 2; mask 4'b0000 -> send pulses with 0/0.
4. Voice 1 never asserts voice_valid -> after 63 WAIT cycles timeout_err = 1, voice 1 contributes 0, the frame completes; clear_flags -> timeout_err = 0.
5. i2s_ready held low 20 cycles after SAT -> outputs hold, send stays 0; ready rises -> exactly one send pulse; frame_tick during the wait -> overrun = 1, no second frame.
6. Reset asserted while in WAIT -> next cycle busy = 0 and all outputs 0; the next frame_tick runs a clean frame.
